// File: rtl/dmi_req_ctrl.sv
// DMI request controller: turns TAP read/write pulses into a single outstanding
// debug-module request, with timeout, sticky error/busy status and read-data capture.
module dmi_req_ctrl #(
    parameter int unsigned AWIDTH    = 7,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [2:0]  IDLE_HINT = 3'd1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              req_wr_en,
    input  logic              req_rd_en,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              dmi_reset,
    input  logic              dmi_hard_reset,
    output logic              dm_req_valid,
    output logic              dm_req_write,
    output logic [AWIDTH-1:0] dm_req_addr,
    output logic [31:0]       dm_req_wdata,
    input  logic              dm_req_ready,
    input  logic              dm_rsp_valid,
    input  logic [31:0]       dm_rsp_rdata,
    input  logic              dm_rsp_err,
    output logic [31:0]       rd_data,
    output logic [1:0]        rd_status,
    output logic [1:0]        dmi_stat,
    output logic [2:0]        idle
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RSP
    } state_t;

    localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_valid;
    logic              r_write;
    logic [AWIDTH-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [1:0]        r_sticky;
    logic [7:0]        r_cnt;

    logic              w_write;
    logic [AWIDTH-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic [1:0]        w_sticky;
    logic [7:0]        w_cnt;
    logic [7:0]        w_cnt_inc;
    logic              w_req_wr;
    logic              w_req_rd;
    logic              w_req;
    logic              w_timeout;
    logic              w_set_err;
    logic              w_set_ovr;

    always_ff @(posedge clk) begin
        if (!rst_l || dmi_hard_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_write     = r_write;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_rdata     = r_rdata;
        w_cnt       = r_cnt;
        w_set_err   = 1'b0;
        w_set_ovr   = 1'b0;

        // Reserved op (both pulses) decodes as no request at all.
        w_req_wr  = req_wr_en & ~req_rd_en;
        w_req_rd  = req_rd_en & ~req_wr_en;
        w_req     = w_req_wr | w_req_rd;
        w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        w_timeout = (w_cnt_inc == TO_VAL);

        case (r_state)
            S_IDLE: begin
                if (w_req && (r_sticky == 2'd0)) begin
                    w_state_nxt = S_REQ;
                    w_write     = w_req_wr;
                    w_addr      = req_addr;
                    w_wdata     = req_wdata;
                    w_cnt       = '0;
                end
            end
            S_REQ: begin
                w_cnt     = w_cnt_inc;
                w_set_ovr = w_req;
                if (dm_req_ready && dm_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                    w_write     = 1'b0;
                    if (!r_write) begin
                        w_rdata = dm_rsp_rdata;
                    end
                    w_set_err = dm_rsp_err;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_write     = 1'b0;
                    w_set_err   = 1'b1;
                end else if (dm_req_ready) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                w_cnt     = w_cnt_inc;
                w_set_ovr = w_req;
                if (dm_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                    w_write     = 1'b0;
                    if (!r_write) begin
                        w_rdata = dm_rsp_rdata;
                    end
                    w_set_err = dm_rsp_err;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_write     = 1'b0;
                    w_set_err   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // First error wins; dmi_reset beats any same-cycle set.
        w_sticky = r_sticky;
        if (dmi_reset) begin
            w_sticky = 2'd0;
        end else if (r_sticky == 2'd0) begin
            if (w_set_err) begin
                w_sticky = 2'd2;
            end else if (w_set_ovr) begin
                w_sticky = 2'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l || dmi_hard_reset) begin
            r_valid  <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_sticky <= 2'd0;
            r_cnt    <= '0;
        end else begin
            r_valid  <= (w_state_nxt == S_REQ);
            r_write  <= w_write;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_rdata  <= w_rdata;
            r_sticky <= w_sticky;
            r_cnt    <= w_cnt;
        end
    end

    assign dm_req_valid = r_valid;
    assign dm_req_write = r_write;
    assign dm_req_addr  = r_addr;
    assign dm_req_wdata = r_wdata;
    assign rd_data      = r_rdata;
    assign rd_status    = (r_state != S_IDLE) ? 2'd3 : r_sticky;
    assign dmi_stat     = r_sticky;
    assign idle         = IDLE_HINT;

endmodule

// File: tb/tb_dmi_req_ctrl.sv
// Directed bench for dmi_req_ctrl (TIMEOUT=8): read/write flows, overrun,
// timeout, error vs. dmi_reset, and abort via hard reset / rst_l.
module tb_dmi_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        req_wr_en;
    logic        req_rd_en;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        dmi_reset;
    logic        dmi_hard_reset;
    logic        dm_req_valid;
    logic        dm_req_write;
    logic [6:0]  dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        dm_rsp_err;
    logic [31:0] rd_data;
    logic [1:0]  rd_status;
    logic [1:0]  dmi_stat;
    logic [2:0]  idle;

    int n_cmp = 0;
    int n_err = 0;

    dmi_req_ctrl #(
        .AWIDTH   (7),
        .TIMEOUT  (8),
        .IDLE_HINT(3'd1)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .req_wr_en     (req_wr_en),
        .req_rd_en     (req_rd_en),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .dmi_reset     (dmi_reset),
        .dmi_hard_reset(dmi_hard_reset),
        .dm_req_valid  (dm_req_valid),
        .dm_req_write  (dm_req_write),
        .dm_req_addr   (dm_req_addr),
        .dm_req_wdata  (dm_req_wdata),
        .dm_req_ready  (dm_req_ready),
        .dm_rsp_valid  (dm_rsp_valid),
        .dm_rsp_rdata  (dm_rsp_rdata),
        .dm_rsp_err    (dm_rsp_err),
        .rd_data       (rd_data),
        .rd_status     (rd_status),
        .dmi_stat      (dmi_stat),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_l = 1'b0; req_wr_en = 1'b0; req_rd_en = 1'b0; req_addr = '0; req_wdata = '0;
        dmi_reset = 1'b0; dmi_hard_reset = 1'b0; dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
        dm_rsp_rdata = '0; dm_rsp_err = 1'b0;
        tick(); tick();
        rst_l = 1'b1;

        chk("rst_valid",  32'(dm_req_valid), 32'd0);
        chk("rst_write",  32'(dm_req_write), 32'd0);
        chk("rst_addr",   32'(dm_req_addr),  32'd0);
        chk("rst_wdata",  dm_req_wdata,      32'd0);
        chk("rst_rdata",  rd_data,           32'd0);
        chk("rst_status", 32'(rd_status),    32'd0);
        chk("rst_stat",   32'(dmi_stat),     32'd0);
        chk("idle_hint",  32'(idle),         32'd1);

        // Read: ready after 2 REQ cycles, response after 3 RSP cycles
        req_rd_en = 1'b1; req_addr = 7'h10; req_wdata = 32'h55;
        tick();
        req_rd_en = 1'b0;
        chk("rd_valid1",  32'(dm_req_valid), 32'd1);
        chk("rd_write",   32'(dm_req_write), 32'd0);
        chk("rd_addr",    32'(dm_req_addr),  32'h10);
        chk("rd_busy1",   32'(rd_status),    32'd3);
        tick();
        chk("rd_valid2",  32'(dm_req_valid), 32'd1);
        dm_req_ready = 1'b1;
        tick();
        dm_req_ready = 1'b0;
        chk("rd_valid_drop", 32'(dm_req_valid), 32'd0);
        chk("rd_busy_rsp",   32'(rd_status),    32'd3);
        tick(); tick();
        chk("rd_busy_rsp3",  32'(rd_status),    32'd3);
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'hDEADBEEF;
        tick();
        dm_rsp_valid = 1'b0;
        chk("rd_data",    rd_data,           32'hDEADBEEF);
        chk("rd_done_st", 32'(rd_status),    32'd0);
        chk("rd_done_ds", 32'(dmi_stat),     32'd0);

        // Stray response in IDLE is ignored
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h12345678;
        tick();
        dm_rsp_valid = 1'b0;
        chk("idle_rsp_ign", rd_data,         32'hDEADBEEF);

        // Write with ready and response together
        req_wr_en = 1'b1; req_addr = 7'h04; req_wdata = 32'h1;
        tick();
        req_wr_en = 1'b0;
        chk("wr_valid",   32'(dm_req_valid), 32'd1);
        chk("wr_write",   32'(dm_req_write), 32'd1);
        chk("wr_addr",    32'(dm_req_addr),  32'h04);
        chk("wr_wdata",   dm_req_wdata,      32'h1);
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'hAAAAAAAA;
        tick();
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
        chk("wr_valid_off", 32'(dm_req_valid), 32'd0);
        chk("wr_write_off", 32'(dm_req_write), 32'd0);
        chk("wr_rdata_keep", rd_data,          32'hDEADBEEF);
        chk("wr_status",    32'(rd_status),    32'd0);

        // Reserved op (both pulses) is ignored
        req_wr_en = 1'b1; req_rd_en = 1'b1;
        tick();
        req_wr_en = 1'b0; req_rd_en = 1'b0;
        chk("resv_valid",  32'(dm_req_valid), 32'd0);
        chk("resv_status", 32'(rd_status),    32'd0);

        // Overrun during RSP
        req_rd_en = 1'b1; req_addr = 7'h20;
        tick();
        req_rd_en = 1'b0; dm_req_ready = 1'b1;
        tick();
        dm_req_ready = 1'b0; req_rd_en = 1'b1;
        tick();
        req_rd_en = 1'b0;
        chk("ovr_stat",   32'(dmi_stat),     32'd3);
        chk("ovr_busy",   32'(rd_status),    32'd3);
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h0BADF00D;
        tick();
        dm_rsp_valid = 1'b0;
        chk("ovr_rdata",  rd_data,           32'h0BADF00D);
        chk("ovr_stat2",  32'(dmi_stat),     32'd3);
        chk("ovr_status", 32'(rd_status),    32'd3);
        req_wr_en = 1'b1;
        tick();
        req_wr_en = 1'b0;
        chk("sticky_drop", 32'(dm_req_valid), 32'd0);
        chk("sticky_keep", 32'(dmi_stat),     32'd3);
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
        chk("clr_stat",   32'(dmi_stat),     32'd0);
        req_rd_en = 1'b1; req_addr = 7'h30;
        tick();
        req_rd_en = 1'b0;
        chk("reaccept",   32'(dm_req_valid), 32'd1);
        chk("reacc_addr", 32'(dm_req_addr),  32'h30);
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h11111111;
        tick();
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
        chk("reacc_rdata", rd_data,          32'h11111111);

        // Timeout: valid high for exactly 8 cycles with ready held low
        req_rd_en = 1'b1; req_addr = 7'h40;
        tick();
        req_rd_en = 1'b0;
        chk("to_valid0", 32'(dm_req_valid), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_valid_hold", 32'(dm_req_valid), 32'd1);
        end
        tick();
        chk("to_valid_drop", 32'(dm_req_valid), 32'd0);
        chk("to_stat",       32'(dmi_stat),     32'd2);
        chk("to_status",     32'(rd_status),    32'd2);
        chk("to_rdata_keep", rd_data,           32'h11111111);
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
        chk("to_clr", 32'(dmi_stat), 32'd0);

        // Error response alone sets sticky=2 and still loads data
        req_rd_en = 1'b1; req_addr = 7'h0C;
        tick();
        req_rd_en = 1'b0;
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b1; dm_rsp_err = 1'b1; dm_rsp_rdata = 32'h600DD00D;
        tick();
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_err = 1'b0;
        chk("err_stat",  32'(dmi_stat), 32'd2);
        chk("err_rdata", rd_data,       32'h600DD00D);
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;

        // Error together with dmi_reset: clear wins
        req_rd_en = 1'b1; req_addr = 7'h08;
        tick();
        req_rd_en = 1'b0;
        dm_req_ready = 1'b1; dm_rsp_valid = 1'b1; dm_rsp_err = 1'b1; dm_rsp_rdata = 32'hCAFEF00D;
        dmi_reset = 1'b1;
        tick();
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_err = 1'b0; dmi_reset = 1'b0;
        chk("errclr_stat",  32'(dmi_stat), 32'd0);
        chk("errclr_rdata", rd_data,       32'hCAFEF00D);

        // Hard reset during REQ, with a competing request
        req_rd_en = 1'b1; req_addr = 7'h50;
        tick();
        req_rd_en = 1'b1; dmi_hard_reset = 1'b1;
        tick();
        req_rd_en = 1'b0; dmi_hard_reset = 1'b0;
        chk("hr_valid",  32'(dm_req_valid), 32'd0);
        chk("hr_rdata",  rd_data,           32'd0);
        chk("hr_stat",   32'(dmi_stat),     32'd0);
        chk("hr_status", 32'(rd_status),    32'd0);
        chk("hr_addr",   32'(dm_req_addr),  32'd0);

        // rst_l during REQ with sticky already set
        req_rd_en = 1'b1; req_addr = 7'h60;
        tick();
        req_rd_en = 1'b0; dm_req_ready = 1'b1; dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h77;
        tick();
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
        chk("pre_rst_rdata", rd_data, 32'h77);
        req_rd_en = 1'b1;
        tick();
        tick();
        req_rd_en = 1'b0;
        chk("pre_rst_stat", 32'(dmi_stat), 32'd3);
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        chk("rl_valid",  32'(dm_req_valid), 32'd0);
        chk("rl_rdata",  rd_data,           32'd0);
        chk("rl_stat",   32'(dmi_stat),     32'd0);
        chk("rl_status", 32'(rd_status),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
